logic_unit_sequencer: RTL
=========================

Name: logic_unit_sequencer

Overview:
- Multicycle controller that drives ALUOp and COUNTER into logic_unit, one operation at a time.
- Accepts operation requests over a valid/ready handshake into a 1-entry pending buffer.
- Steps COUNTER through each operation's fixed step count and raises a completion pulse with result-write, overflow-exception and branch-decision qualifiers.
- Sits between the main control FSM and logic_unit.

Parameters:
- OP_W, 4, width of ALUOp / request opcode.
- CNT_W, 2, width of COUNTER.
- OVF_TRAP, 1, when 1, arithmetic overflow suppresses result_we and pulses ovf_exc; when 0, overflow is ignored.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_op  in  OP_W  requested operation code.
- req_ready  out  1  pending buffer can accept.
- OVERFLOW  in  1  from logic_unit.
- Update_UC  in  1  from logic_unit; branch condition true.
- ALUOp  out  OP_W  to logic_unit (registered).
- COUNTER  out  CNT_W  to logic_unit; current step index (registered).
- busy  out  1  operation in RUN.
- done  out  1  one-cycle completion pulse.
- result_we  out  1  with done: ALUOut must be written.
- ovf_exc  out  1  with done: overflow trap.
- branch_taken  out  1  with done: branch condition latched.

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high. On reset:
  - state=IDLE, pending empty.
  - ALUOp=0, COUNTER=0.
  - busy=0, done=0, result_we=0, ovf_exc=0, branch_taken=0, req_ready=1.
  - Reset mid-operation aborts the operation with no done pulse and discards the pending entry.
- Opcodes and step counts (N):
  - 0 NOP: N=1, no write.
  - 1 ADD, 2 SUB: N=1, arithmetic (overflow-checked).
  - 3 AND, 4 OR, 5 XOR, 6 SLT, 7 PASSA: N=1.
  - 8 SLL, 9 SRL, A SRA, B SLLV, C SRAV: N=3 (load, shift, read).
  - D BEQ, E BNE, F BGT: N=2, no write.
- Handshake:
  - A request transfers when req_valid && req_ready.
  - req_ready = !pending_full.
  - A transferred request enters the pending register.
  - If IDLE and the pending register is empty, a transferred request bypasses into RUN on the next edge without a bubble.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when pending full or a request transfers. Load ALUOp=op, COUNTER=0, busy=1.
  - RUN: COUNTER increments each cycle while COUNTER < N-1.
  - RUN -> DONE: on the cycle COUNTER==N-1, sample OVERFLOW and Update_UC and go to DONE.
  - DONE (exactly 1 cycle): done=1.
    - result_we=1 for write ops, unless OVF_TRAP && overflow sampled on ADD/SUB; in that case result_we=0 and ovf_exc=1.
    - branch_taken = sampled Update_UC for D/E/F, else 0.
    - busy=0. COUNTER returns to 0; ALUOp holds its last value.
  - DONE -> RUN directly if pending is full (back-to-back, one-cycle gap); else DONE -> IDLE.
- Latency: a request accepted in IDLE at edge t gives RUN with COUNTER=0 visible after t+1, and done visible in cycle t+1+N.
- Pending buffer: at most one queued op. A request arriving while busy is queued; req_ready drops until the queued op enters RUN. Pending-register dequeue and enqueue in the same cycle are both allowed.
- COUNTER never exceeds N-1. An illegal state recovers to IDLE.
- done, result_we, ovf_exc and branch_taken are never high outside DONE.

Test Plan:
- Reset, then a single ADD (op=1) with OVERFLOW=0 -> ALUOp=1, COUNTER=0 for 1 cycle; next cycle done=1, result_we=1, ovf_exc=0, busy falls.
- SRA (op=A) -> COUNTER sequence 0,1,2 on consecutive cycles, ALUOp=A throughout; done one cycle after COUNTER=2, result_we=1.
- SUB with OVERFLOW=1 at the final step, OVF_TRAP=1 -> done=1, result_we=0, ovf_exc=1. Repeat with OVF_TRAP=0 -> result_we=1, ovf_exc=0.
- BNE (op=E) with Update_UC=1 at COUNTER=1 -> done=1, branch_taken=1, result_we=0. BEQ with Update_UC=0 -> branch_taken=0.
- SLL issued, then AND issued while busy, then a third request -> AND queued and req_ready=0. The third request stalls until AND leaves the pending register. AND enters RUN the cycle after SLL's done with COUNTER=0.
- Reset asserted at COUNTER=1 of an SRL with a pending XOR -> next cycle all outputs at reset values, no done pulse, req_ready=1, XOR never executes.

Source files
------------

// File: rtl/logic_unit_sequencer.sv
// Multicycle sequencer for logic_unit: accepts ops over valid/ready, steps COUNTER
// through each op's step count, and reports completion with write/trap/branch qualifiers.
//
// state | meaning
// IDLE  | no operation in flight; a request or a queued op starts RUN next edge
// RUN   | ALUOp/COUNTER driven into logic_unit, COUNTER advancing to N-1
// DONE  | one-cycle completion; qualifiers valid alongside done
module logic_unit_sequencer #(
  parameter int OP_W     = 4,
  parameter int CNT_W    = 2,
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [OP_W-1:0]  req_op,
  output logic             req_ready,
  input  logic             OVERFLOW,
  input  logic             Update_UC,
  output logic [OP_W-1:0]  ALUOp,
  output logic [CNT_W-1:0] COUNTER,
  output logic             busy,
  output logic             done,
  output logic             result_we,
  output logic             ovf_exc,
  output logic             branch_taken
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SRAV = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BGT  = OP_W'(15);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_full_q, pend_full_d;
  logic [OP_W-1:0]  pend_op_q, pend_op_d;
  logic             we_q, we_d;
  logic             exc_q, exc_d;
  logic             br_q, br_d;

  logic             xfer;
  logic             bypass;
  logic             deq;
  logic             ovf_hit;
  logic [CNT_W-1:0] last_cnt;

  function automatic logic [CNT_W-1:0] last_step(input logic [OP_W-1:0] op);
    if (op >= OP_BEQ && op <= OP_BGT) return CNT_W'(1);
    else if (op >= OP_SLL && op <= OP_SRAV) return CNT_W'(2);
    else return '0;
  endfunction

  function automatic logic is_write(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SRAV);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGT);
  endfunction

  assign req_ready = !pend_full_q;
  assign xfer      = req_valid && req_ready;
  assign last_cnt  = last_step(alu_op_q);
  assign ovf_hit   = OVF_TRAP && OVERFLOW && (alu_op_q == OP_ADD || alu_op_q == OP_SUB);

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_op_d   = pend_op_q;
    we_d        = we_q;
    exc_d       = exc_q;
    br_d        = br_q;
    bypass      = 1'b0;
    deq         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          state_d  = S_RUN;
          alu_op_d = pend_op_q;
          cnt_d    = '0;
          deq      = 1'b1;
        end else if (xfer) begin
          state_d  = S_RUN;
          alu_op_d = req_op;
          cnt_d    = '0;
          bypass   = 1'b1;
        end
      end
      S_RUN: begin
        // >= rather than == so a corrupted count still terminates the op
        if (cnt_q >= last_cnt) begin
          state_d = S_DONE;
          cnt_d   = '0;
          we_d    = is_write(alu_op_q) && !ovf_hit;
          exc_d   = ovf_hit;
          br_d    = is_branch(alu_op_q) && Update_UC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (pend_full_q) begin
          state_d  = S_RUN;
          alu_op_d = pend_op_q;
          cnt_d    = '0;
          deq      = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (deq) pend_full_d = 1'b0;
    if (xfer && !bypass) begin
      pend_full_d = 1'b1;
      pend_op_d   = req_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      alu_op_q    <= '0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_op_q   <= '0;
      we_q        <= 1'b0;
      exc_q       <= 1'b0;
      br_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_op_q   <= pend_op_d;
      we_q        <= we_d;
      exc_q       <= exc_d;
      br_q        <= br_d;
    end
  end

  // Qualifiers are latched at the last RUN step and only exposed in DONE.
  assign ALUOp        = alu_op_q;
  assign COUNTER      = cnt_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign result_we    = done && we_q;
  assign ovf_exc      = done && exc_q;
  assign branch_taken = done && br_q;

endmodule
